// File: rtl/bidir_dir_sequencer_pkg.sv
// Shared types and constants for the bidirectional buffer direction sequencer.
// Direction constants match the buffer ctrl polarity (1 = A drives B).
package bidir_dir_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A2B  = 2'd1,
        TURN = 2'd2,
        B2A  = 2'd3
    } state_t;

    localparam logic DIR_A2B = 1'b1;
    localparam logic DIR_B2A = 1'b0;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bidir_dir_sequencer_turn_timer.sv
// Loadable down-counter that times the tristated turnaround window.
// done is high on the last cycle of the window so the FSM leaves TURN on time.
module bidir_turn_timer
    import bidir_dir_sequencer_pkg::*;
#(
    parameter int TA_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int CW = cnt_width(TA_CYCLES);
    localparam logic [CW-1:0] TA_LOAD = CW'(TA_CYCLES);
    localparam logic [CW-1:0] LAST    = CW'(1);

    logic [CW-1:0] ta_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ta_cnt <= '0;
        end else if (load) begin
            ta_cnt <= TA_LOAD;
        end else if (ta_cnt != '0) begin
            ta_cnt <= ta_cnt - 1'b1;
        end
    end

    assign done = (ta_cnt == LAST);

endmodule

// File: rtl/bidir_dir_sequencer.sv
// Direction sequencer for a bidirectional buffer: arbitrates local TX against
// remote RX requests, inserts turnaround gaps and caps bursts for fairness.
module bidir_dir_sequencer
    import bidir_dir_sequencer_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BURST = 4,
    parameter int TA_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic         rx_req,
    input  logic [W-1:0] bus_in,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic [W-1:0] bus_out,
    output logic         bus_strobe,
    output logic         buf_ctrl,
    output logic         buf_en,
    output logic         busy
);

    localparam int BW = cnt_width(MAX_BURST);
    localparam logic [BW-1:0] CAP = BW'(MAX_BURST);

    state_t        state, state_nx;
    logic [BW-1:0] beat_cnt;
    logic          last_dir;
    logic          below_cap, accept, take;
    logic          turn_load, turn_done, clear_cnt;
    logic          dir_nx, idle_target;

    bidir_turn_timer #(
        .TA_CYCLES(TA_CYCLES)
    ) u_turn_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (turn_load),
        .done (turn_done)
    );

    // Exits from A2B/B2A are only taken on a cycle without a beat, so the
    // final beat is always driven while the buffer is still enabled.
    always_comb begin
        below_cap   = (beat_cnt < CAP);
        accept      = (state == A2B) && tx_valid && below_cap;
        take        = (state == B2A) && rx_req && below_cap;
        state_nx    = state;
        turn_load   = 1'b0;
        clear_cnt   = 1'b0;
        dir_nx      = buf_ctrl;
        idle_target = DIR_A2B;

        case (state)
            IDLE: begin
                if (tx_valid || rx_req) begin
                    if (tx_valid && rx_req) idle_target = ~last_dir;
                    else if (tx_valid)      idle_target = DIR_A2B;
                    else                    idle_target = DIR_B2A;

                    if (idle_target == buf_ctrl) begin
                        state_nx  = (idle_target == DIR_A2B) ? A2B : B2A;
                        clear_cnt = 1'b1;
                    end else begin
                        state_nx  = TURN;
                        turn_load = 1'b1;
                        dir_nx    = idle_target;
                    end
                end
            end
            TURN: begin
                if (turn_done) begin
                    state_nx  = (buf_ctrl == DIR_A2B) ? A2B : B2A;
                    clear_cnt = 1'b1;
                end
            end
            A2B: begin
                if (!accept) begin
                    if (rx_req) begin
                        state_nx  = TURN;
                        turn_load = 1'b1;
                        dir_nx    = DIR_B2A;
                    end else if (!tx_valid) begin
                        state_nx = IDLE;
                    end else begin
                        clear_cnt = 1'b1;
                    end
                end
            end
            B2A: begin
                if (!take) begin
                    if (tx_valid) begin
                        state_nx  = TURN;
                        turn_load = 1'b1;
                        dir_nx    = DIR_A2B;
                    end else if (!rx_req) begin
                        state_nx = IDLE;
                    end else begin
                        clear_cnt = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            buf_ctrl   <= DIR_A2B;
            last_dir   <= DIR_B2A;
            beat_cnt   <= '0;
            bus_out    <= '0;
            bus_strobe <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            buf_ctrl   <= dir_nx;
            bus_strobe <= accept;
            rx_valid   <= take;
            if (accept) bus_out <= tx_data;
            if (take)   rx_data <= bus_in;
            if (clear_cnt)           beat_cnt <= '0;
            else if (accept || take) beat_cnt <= beat_cnt + 1'b1;
            if (state == A2B)      last_dir <= DIR_A2B;
            else if (state == B2A) last_dir <= DIR_B2A;
        end
    end

    // Buffer controls decode from registered state only.
    assign buf_en   = (state == A2B) || (state == B2A);
    assign tx_ready = (state == A2B) && below_cap;
    assign busy     = (state != IDLE);

endmodule
